// File: rtl/stbuf_pkg.sv
// Shared types, widths and byte-mask helper for the store buffer and its forwarding logic.
// No state, no latency, no backpressure of its own.
package stbuf_pkg;
    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 3;
    localparam int REG_DATA_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int STBUF_MAX_SIZE = 4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [SIZE_WIDTH-1:0]     size;
        logic [REG_DATA_WIDTH-1:0] data;
    } stbuf_entry_t;

    // Bit k set for every byte lane k below the access size.
    function automatic logic [STBUF_MAX_SIZE-1:0] byte_mask(input logic [SIZE_WIDTH-1:0] size);
        logic [STBUF_MAX_SIZE-1:0] m;
        m = '0;
        for (int k = 0; k < STBUF_MAX_SIZE; k++)
            m[k] = (int'(size) > k);
        return m;
    endfunction

    function automatic logic size_legal(input logic [SIZE_WIDTH-1:0] size);
        return (size == SIZE_WIDTH'(1)) || (size == SIZE_WIDTH'(2)) || (size == SIZE_WIDTH'(4));
    endfunction
endpackage

// File: rtl/stbuf_forward.sv
// Combinational byte-wise match of a load against pending stores, youngest match per byte wins.
// Zero latency, no backpressure; STBUF_FORWARD_EN selects hit/data outputs, otherwise an overlap flag.
module stbuf_forward
    import stbuf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]     ent_addr,
    input  logic [DEPTH-1:0][SIZE_WIDTH-1:0]     ent_size,
`ifdef STBUF_FORWARD_EN
    input  logic [DEPTH-1:0][REG_DATA_WIDTH-1:0] ent_data,
`endif
    input  logic [DEPTH-1:0]                     valid,
    input  logic [$clog2(DEPTH)-1:0]             head,
    input  logic [ADDR_WIDTH-1:0]                load_addr,
    input  logic [SIZE_WIDTH-1:0]                load_size,
`ifdef STBUF_FORWARD_EN
    output logic [STBUF_MAX_SIZE-1:0]            hit,
    output logic [REG_DATA_WIDTH-1:0]            fwd_data
`else
    output logic                                 overlap
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [STBUF_MAX_SIZE-1:0] hit_c;
    logic [REG_DATA_WIDTH-1:0] fwd_c;

    always_comb begin
        logic [PW-1:0]             idx;
        logic [ADDR_WIDTH-1:0]     off;
        logic [STBUF_MAX_SIZE-1:0] lmask;
        idx   = '0;
        off   = '0;
        lmask = byte_mask(load_size);
        hit_c = '0;
        fwd_c = '0;
        // Walk oldest to youngest so a later match overwrites an earlier one.
        for (int j = 0; j < DEPTH; j++) begin
            idx = head + PW'(j);
            for (int k = 0; k < STBUF_MAX_SIZE; k++) begin
                off = load_addr + ADDR_WIDTH'(k) - ent_addr[idx];
                if (valid[idx] && lmask[k] && (off < ADDR_WIDTH'(ent_size[idx]))) begin
                    hit_c[k] = 1'b1;
`ifdef STBUF_FORWARD_EN
                    fwd_c[8*k +: 8] = ent_data[idx][{off[1:0], 3'b000} +: 8];
`endif
                end
            end
        end
    end

`ifdef STBUF_FORWARD_EN
    assign hit      = hit_c;
    assign fwd_data = fwd_c;
`else
    assign overlap  = |hit_c;
`endif
endmodule

// File: rtl/store_buffer.sv
// Store FIFO draining oldest-first to the TCM; loads get result one cycle after request, merged with or blocked by pending stores (STBUF_FORWARD_EN).
// Push refused while full (registered count); drain stalls on bus_stbuf_write_ready=0 with the head fields held.
module store_buffer
    import stbuf_pkg::*;
#(
    parameter int STBUF_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lsu_stbuf_push,
    input  logic [ADDR_WIDTH-1:0]     lsu_stbuf_addr,
    input  logic [SIZE_WIDTH-1:0]     lsu_stbuf_size,
    input  logic [REG_DATA_WIDTH-1:0] lsu_stbuf_data,
    output logic                      stbuf_lsu_full,
    input  logic                      lsu_stbuf_rd,
    input  logic [ADDR_WIDTH-1:0]     lsu_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]     lsu_stbuf_read_size,
    output logic [REG_DATA_WIDTH-1:0] stbuf_lsu_data,
    output logic                      stbuf_lsu_data_valid,
    output logic                      stbuf_lsu_conflict,
    output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
    output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
    output logic [REG_DATA_WIDTH-1:0] stbuf_bus_data,
    output logic                      stbuf_bus_wr,
    input  logic                      bus_stbuf_write_ready,
    output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
    output logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
    output logic                      stbuf_bus_rd,
    input  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_data
);
    localparam int PW = $clog2(STBUF_DEPTH);

    stbuf_entry_t [STBUF_DEPTH-1:0] entries;
    logic [PW-1:0]                  head, tail;
    logic [PW:0]                    count, count_nxt;
    logic                           wr_q;
    logic                           push_acc, retire;
    logic [STBUF_DEPTH-1:0]         valid;
    logic [STBUF_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
    logic [STBUF_DEPTH-1:0][SIZE_WIDTH-1:0] ent_size;

    assign stbuf_lsu_full = (count == (PW+1)'(STBUF_DEPTH));
    // Illegal-size pushes are consumed but never allocate an entry.
    assign push_acc  = lsu_stbuf_push && !stbuf_lsu_full && size_legal(lsu_stbuf_size);
    assign retire    = wr_q && bus_stbuf_write_ready;
    assign count_nxt = count + (PW+1)'(push_acc) - (PW+1)'(retire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            wr_q  <= 1'b0;
        end else begin
            if (push_acc) tail <= tail + PW'(1);
            if (retire)   head <= head + PW'(1);
            count <= count_nxt;
            wr_q  <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc)
            entries[tail] <= '{addr: lsu_stbuf_addr, size: lsu_stbuf_size, data: lsu_stbuf_data};
    end

    assign stbuf_bus_wr         = wr_q;
    assign stbuf_bus_write_addr = wr_q ? entries[head].addr : '0;
    assign stbuf_bus_write_size = wr_q ? entries[head].size : '0;
    assign stbuf_bus_data       = wr_q ? entries[head].data : '0;

    assign stbuf_bus_rd        = lsu_stbuf_rd;
    assign stbuf_bus_read_addr = lsu_stbuf_read_addr;
    assign stbuf_bus_read_size = lsu_stbuf_read_size;

    always_comb begin
        logic [PW-1:0] rel;
        rel   = '0;
        valid = '0;
        for (int i = 0; i < STBUF_DEPTH; i++) begin
            rel      = PW'(i) - head;
            valid[i] = ({1'b0, rel} < count);
        end
    end

    for (genvar i = 0; i < STBUF_DEPTH; i++) begin : g_slice
        assign ent_addr[i] = entries[i].addr;
        assign ent_size[i] = entries[i].size;
    end

    logic                      rd_q;
    logic [STBUF_MAX_SIZE-1:0] mask_q;

`ifdef STBUF_FORWARD_EN
    logic [STBUF_DEPTH-1:0][REG_DATA_WIDTH-1:0] ent_data;
    logic [STBUF_MAX_SIZE-1:0] hit, hit_q;
    logic [REG_DATA_WIDTH-1:0] fwd_data, fwd_q;

    for (genvar i = 0; i < STBUF_DEPTH; i++) begin : g_data
        assign ent_data[i] = entries[i].data;
    end

    stbuf_forward #(.DEPTH(STBUF_DEPTH)) u_forward (
        .ent_addr  (ent_addr),
        .ent_size  (ent_size),
        .ent_data  (ent_data),
        .valid     (valid),
        .head      (head),
        .load_addr (lsu_stbuf_read_addr),
        .load_size (lsu_stbuf_read_size),
        .hit       (hit),
        .fwd_data  (fwd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= 1'b0;
            mask_q <= '0;
            hit_q  <= '0;
            fwd_q  <= '0;
        end else begin
            rd_q <= lsu_stbuf_rd;
            if (lsu_stbuf_rd) begin
                mask_q <= byte_mask(lsu_stbuf_read_size);
                hit_q  <= hit;
                fwd_q  <= fwd_data;
            end
        end
    end

    assign stbuf_lsu_conflict = 1'b0;

    always_comb begin
        stbuf_lsu_data = '0;
        for (int k = 0; k < STBUF_MAX_SIZE; k++)
            if (rd_q && mask_q[k])
                stbuf_lsu_data[8*k +: 8] = hit_q[k] ? fwd_q[8*k +: 8] : bus_stbuf_data[8*k +: 8];
    end
`else
    logic overlap, ovl_q;

    stbuf_forward #(.DEPTH(STBUF_DEPTH)) u_forward (
        .ent_addr  (ent_addr),
        .ent_size  (ent_size),
        .valid     (valid),
        .head      (head),
        .load_addr (lsu_stbuf_read_addr),
        .load_size (lsu_stbuf_read_size),
        .overlap   (overlap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= 1'b0;
            mask_q <= '0;
            ovl_q  <= 1'b0;
        end else begin
            rd_q <= lsu_stbuf_rd;
            if (lsu_stbuf_rd) begin
                mask_q <= byte_mask(lsu_stbuf_read_size);
                ovl_q  <= overlap;
            end
        end
    end

    assign stbuf_lsu_conflict = rd_q && ovl_q;

    always_comb begin
        stbuf_lsu_data = '0;
        for (int k = 0; k < STBUF_MAX_SIZE; k++)
            if (rd_q && !ovl_q && mask_q[k])
                stbuf_lsu_data[8*k +: 8] = bus_stbuf_data[8*k +: 8];
    end
`endif

    assign stbuf_lsu_data_valid = rd_q;
endmodule

// File: tb/tb_store_buffer.sv
// Random and directed bench for store_buffer with a queue-based store model and a byte-array TCM.
`timescale 1ns/1ps
module tb_store_buffer;
    import stbuf_pkg::*;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_stbuf_push = 1'b0;
    logic [31:0] lsu_stbuf_addr = '0;
    logic [2:0]  lsu_stbuf_size = '0;
    logic [31:0] lsu_stbuf_data = '0;
    logic        stbuf_lsu_full;
    logic        lsu_stbuf_rd = 1'b0;
    logic [31:0] lsu_stbuf_read_addr = '0;
    logic [2:0]  lsu_stbuf_read_size = '0;
    logic [31:0] stbuf_lsu_data;
    logic        stbuf_lsu_data_valid;
    logic        stbuf_lsu_conflict;
    logic [31:0] stbuf_bus_write_addr;
    logic [2:0]  stbuf_bus_write_size;
    logic [31:0] stbuf_bus_data;
    logic        stbuf_bus_wr;
    logic        bus_stbuf_write_ready = 1'b1;
    logic [31:0] stbuf_bus_read_addr;
    logic [2:0]  stbuf_bus_read_size;
    logic        stbuf_bus_rd;
    logic [31:0] bus_stbuf_data = '0;

    store_buffer #(.STBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .lsu_stbuf_push(lsu_stbuf_push), .lsu_stbuf_addr(lsu_stbuf_addr),
        .lsu_stbuf_size(lsu_stbuf_size), .lsu_stbuf_data(lsu_stbuf_data),
        .stbuf_lsu_full(stbuf_lsu_full),
        .lsu_stbuf_rd(lsu_stbuf_rd), .lsu_stbuf_read_addr(lsu_stbuf_read_addr),
        .lsu_stbuf_read_size(lsu_stbuf_read_size),
        .stbuf_lsu_data(stbuf_lsu_data), .stbuf_lsu_data_valid(stbuf_lsu_data_valid),
        .stbuf_lsu_conflict(stbuf_lsu_conflict),
        .stbuf_bus_write_addr(stbuf_bus_write_addr), .stbuf_bus_write_size(stbuf_bus_write_size),
        .stbuf_bus_data(stbuf_bus_data), .stbuf_bus_wr(stbuf_bus_wr),
        .bus_stbuf_write_ready(bus_stbuf_write_ready),
        .stbuf_bus_read_addr(stbuf_bus_read_addr), .stbuf_bus_read_size(stbuf_bus_read_size),
        .stbuf_bus_rd(stbuf_bus_rd), .bus_stbuf_data(bus_stbuf_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // TCM: byte array, write-first, one-cycle registered read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (stbuf_bus_wr && bus_stbuf_write_ready)
            for (int k = 0; k < 4; k++)
                if (k < int'(stbuf_bus_write_size))
                    mem[8'(stbuf_bus_write_addr + 32'(k))] = stbuf_bus_data[8*k +: 8];
        if (stbuf_bus_rd)
            for (int k = 0; k < 4; k++)
                bus_stbuf_data[8*k +: 8] <= mem[8'(stbuf_bus_read_addr + 32'(k))];
    end

    // Reference model: queue of pending stores, oldest at the front.
    typedef struct {
        logic [31:0] addr;
        int          size;
        logic [31:0] data;
    } st_t;
    st_t         q[$];
    logic        pend_vld = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_size = 0;
    logic [3:0]  pend_hit = '0;
    logic [7:0]  pend_b [4];

    always @(negedge rst) begin
        q.delete();
        pend_vld = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            int n;
            int s;
            n = q.size();
            pend_vld = lsu_stbuf_rd;
            if (lsu_stbuf_rd) begin
                pend_addr = lsu_stbuf_read_addr;
                pend_size = int'(lsu_stbuf_read_size);
                pend_hit  = '0;
                for (int k = 0; k < pend_size; k++) begin
                    logic [31:0] a;
                    a = pend_addr + 32'(k);
                    foreach (q[j]) begin
                        logic [31:0] d;
                        d = a - q[j].addr;
                        if (d < 32'(q[j].size)) begin
                            pend_hit[k] = 1'b1;
                            pend_b[k]   = q[j].data[8*d +: 8];
                        end
                    end
                end
            end
            if (n > 0 && bus_stbuf_write_ready)
                void'(q.pop_front());
            s = int'(lsu_stbuf_size);
            if (lsu_stbuf_push && n < DEPTH && (s == 1 || s == 2 || s == 4))
                q.push_back('{addr: lsu_stbuf_addr, size: s, data: lsu_stbuf_data});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] exp_d;
        logic        exp_c;
        chk("wr", 32'(stbuf_bus_wr), 32'(q.size() != 0));
        chk("full", 32'(stbuf_lsu_full), 32'(q.size() == DEPTH));
        if (q.size() != 0) begin
            chk("waddr", stbuf_bus_write_addr, q[0].addr);
            chk("wsize", 32'(stbuf_bus_write_size), 32'(q[0].size));
            chk("wdata", stbuf_bus_data, q[0].data);
        end
        exp_d = '0;
        exp_c = 1'b0;
        if (pend_vld) begin
`ifdef STBUF_FORWARD_EN
            for (int k = 0; k < pend_size && k < 4; k++)
                exp_d[8*k +: 8] = pend_hit[k] ? pend_b[k] : mem[8'(pend_addr + 32'(k))];
`else
            if (pend_hit != 4'b0)
                exp_c = 1'b1;
            else
                for (int k = 0; k < pend_size && k < 4; k++)
                    exp_d[8*k +: 8] = mem[8'(pend_addr + 32'(k))];
`endif
        end
        chk("ld_valid", 32'(stbuf_lsu_data_valid), 32'(pend_vld));
        chk("ld_data", stbuf_lsu_data, exp_d);
        chk("ld_conflict", 32'(stbuf_lsu_conflict), 32'(exp_c));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_push(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        lsu_stbuf_push = 1'b1;
        lsu_stbuf_addr = a;
        lsu_stbuf_size = s;
        lsu_stbuf_data = d;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] s);
        lsu_stbuf_rd        = 1'b1;
        lsu_stbuf_read_addr = a;
        lsu_stbuf_read_size = s;
    endtask

    task automatic drain();
        bus_stbuf_write_ready = 1'b1;
        for (int n = 0; n < 20 && stbuf_bus_wr; n++)
            step();
        chk("drain_empty", 32'(stbuf_bus_wr), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        return 32'($urandom_range(0, 23));
    endfunction

    function automatic logic [2:0] rand_size();
        int r;
        r = $urandom_range(0, 15);
        if (r < 5)   return 3'd1;
        if (r < 10)  return 3'd2;
        if (r < 14)  return 3'd4;
        if (r == 14) return 3'd0;
        return ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd5;
    endfunction

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_wr", 32'(stbuf_bus_wr), 32'd0);
        chk("rst_full", 32'(stbuf_lsu_full), 32'd0);
        chk("rst_valid", 32'(stbuf_lsu_data_valid), 32'd0);
        chk("rst_conflict", 32'(stbuf_lsu_conflict), 32'd0);
        chk("rst_data", stbuf_lsu_data, 32'd0);
        chk("rst_waddr", stbuf_bus_write_addr, 32'd0);
        chk("rst_wdata", stbuf_bus_data, 32'd0);
        rst = 1'b1;

        // Single byte store reaches the bus the next cycle and retires.
        set_push(32'h0, 3'd1, 32'h0000_00a5);
        step();
        lsu_stbuf_push = 1'b0;
        chk("t1_wr", 32'(stbuf_bus_wr), 32'd1);
        chk("t1_addr", stbuf_bus_write_addr, 32'h0);
        chk("t1_data", stbuf_bus_data, 32'h0000_00a5);
        step();
        chk("t1_empty", 32'(stbuf_bus_wr), 32'd0);

        // Fill, refused ninth push, then push/retire interplay at and just below full.
        bus_stbuf_write_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_push(32'(4 * i), 3'd4, 32'(i));
            step();
        end
        chk("t2_full", 32'(stbuf_lsu_full), 32'd1);
        set_push(32'h20, 3'd4, 32'h99);
        step();
        lsu_stbuf_push = 1'b0;
        chk("t2_still_full", 32'(stbuf_lsu_full), 32'd1);
        chk("t2_head", stbuf_bus_write_addr, 32'h0);
        bus_stbuf_write_ready = 1'b1;
        set_push(32'h40, 3'd4, 32'h40);
        step();
        chk("t5_count7", 32'(stbuf_lsu_full), 32'd0);
        chk("t5_head1", stbuf_bus_write_addr, 32'h4);
        set_push(32'h44, 3'd4, 32'h44);
        step();
        lsu_stbuf_push = 1'b0;
        chk("t5_head2", stbuf_bus_write_addr, 32'h8);
        for (int i = 2; i < 8; i++) begin
            chk("t2_order_addr", stbuf_bus_write_addr, 32'(4 * i));
            chk("t2_order_data", stbuf_bus_data, 32'(i));
            step();
        end
        chk("t5_last", stbuf_bus_write_addr, 32'h44);
        step();
        chk("t2_empty", 32'(stbuf_bus_wr), 32'd0);

        // Partial overlap merge against TCM word 0x90abcdef.
        mem[8] = 8'hef; mem[9] = 8'hcd; mem[10] = 8'hab; mem[11] = 8'h90;
        bus_stbuf_write_ready = 1'b0;
        set_push(32'h9, 3'd2, 32'h0000_a55a);
        step();
        lsu_stbuf_push = 1'b0;
        set_load(32'h8, 3'd4);
        step();
        lsu_stbuf_rd = 1'b0;
        chk("t3_valid", 32'(stbuf_lsu_data_valid), 32'd1);
`ifdef STBUF_FORWARD_EN
        chk("t3_data", stbuf_lsu_data, 32'h90a5_5aef);
        chk("t3_conflict", 32'(stbuf_lsu_conflict), 32'd0);
`else
        chk("t3_data", stbuf_lsu_data, 32'h0);
        chk("t3_conflict", 32'(stbuf_lsu_conflict), 32'd1);
`endif
        drain();

        // Youngest store wins per byte.
        bus_stbuf_write_ready = 1'b0;
        set_push(32'h10, 3'd4, 32'h1122_3344);
        step();
        set_push(32'h10, 3'd1, 32'h0000_00cc);
        step();
        lsu_stbuf_push = 1'b0;
        set_load(32'h10, 3'd4);
        step();
        lsu_stbuf_rd = 1'b0;
`ifdef STBUF_FORWARD_EN
        chk("t4_data", stbuf_lsu_data, 32'h1122_33cc);
`else
        chk("t4_data", stbuf_lsu_data, 32'h0);
        chk("t4_conflict", 32'(stbuf_lsu_conflict), 32'd1);
`endif
        drain();

        // Asynchronous reset with stores pending and a load result on the outputs.
        bus_stbuf_write_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h20 + 32'(4 * i), 3'd4, 32'hdead_0000 + 32'(i));
            step();
        end
        lsu_stbuf_push = 1'b0;
        bus_stbuf_write_ready = 1'b1;
        set_load(32'h20, 3'd4);
        step();
        lsu_stbuf_rd = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_wr", 32'(stbuf_bus_wr), 32'd0);
        chk("t6_waddr", stbuf_bus_write_addr, 32'd0);
        chk("t6_wdata", stbuf_bus_data, 32'd0);
        chk("t6_valid", 32'(stbuf_lsu_data_valid), 32'd0);
        chk("t6_data", stbuf_lsu_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) step();
        chk("t6_no_stale", 32'(stbuf_bus_wr), 32'd0);

        // Randomized traffic; ready probability varies by phase to exercise full and empty.
        for (int c = 0; c < 3000; c++) begin
            lsu_stbuf_push        = ($urandom_range(0, 1) == 1);
            lsu_stbuf_addr        = rand_addr();
            lsu_stbuf_size        = rand_size();
            lsu_stbuf_data        = $urandom;
            bus_stbuf_write_ready = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                         : ($urandom_range(0, 3) != 0);
            lsu_stbuf_rd          = ($urandom_range(0, 1) == 1);
            lsu_stbuf_read_addr   = rand_addr();
            case ($urandom_range(0, 2))
                0:       lsu_stbuf_read_size = 3'd1;
                1:       lsu_stbuf_read_size = 3'd2;
                default: lsu_stbuf_read_size = 3'd4;
            endcase
            step();
        end
        lsu_stbuf_push = 1'b0;
        lsu_stbuf_rd   = 1'b0;
        drain();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
